sprite_rom_bank: RTL and testbench
==================================

Name: sprite_rom_bank

Overview:
- Parametrised multi-sprite, multi-frame successor to the single-sprite synchronous ROMs.
- Holds NUM_SPR sprites of ANIM_FRAMES frames each, all SPR_W x SPR_H palette indices, in one initialised memory.
- Converts a per-pixel (sprite, x, y) request into a palette index through a 2-cycle valid-tagged pipeline, with a built-in animation frame counter.
- Sits between the VGA pixel-coordinate logic and the palette/colour mapper.

Parameters:
- DATA_W, 3: palette index width.
- SPR_W, 32: sprite width in pixels.
- SPR_H, 32: sprite height in pixels.
- NUM_SPR, 4: number of sprites.
- ANIM_FRAMES, 4: frames per sprite; 1 disables animation.
- ANIM_DIV, 8: frame_tick pulses per animation step.
- TRANSP_IDX, 0: palette index treated as transparent.
- INIT_FILE, "./sprites/sprites.mif": ram_init_file for the memory.

Ports:
- clock, in, 1: system clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per video frame (vsync edge).
- anim_en, in, 1: 1 = animation counter advances; 0 = counter holds.
- req_valid, in, 1: pixel request strobe.
- req_sprite, in, SW=$clog2(NUM_SPR) (min 1): sprite number.
- req_x, in, $clog2(SPR_W): column within the sprite.
- req_y, in, $clog2(SPR_H): row within the sprite.
- out_valid, out, 1: result valid; exactly 2 cycles after req_valid.
- out_index, out, DATA_W: palette index.
- out_transparent, out, 1: 1 if the pixel must not be drawn.
- anim_frame, out, $clog2(ANIM_FRAMES) (min 1): current animation frame.

Behaviour:
- Memory:
  - DEPTH = NUM_SPR*ANIM_FRAMES*SPR_H*SPR_W words of DATA_W bits.
  - Synchronous read; no write port; no reset on the memory array.
- Address computation:
  - addr = ((req_sprite*ANIM_FRAMES + anim_frame)*SPR_H + req_y)*SPR_W + req_x.
  - Computed at full width, then truncated to $clog2(DEPTH) bits.
  - anim_frame is sampled in the request cycle, so a tick arriving mid-flight does not alter an in-flight request.
- Pipeline (fully pipelined, one request accepted per cycle, no backpressure):
  - S1 (cycle N): register addr, valid, and an oob flag (req_sprite >= NUM_SPR, or req_x >= SPR_W, or req_y >= SPR_H).
  - S2 (cycle N+1): memory read and tag forwarding.
  - Output (cycle N+2):
    - out_valid=1.
    - out_index = oob ? TRANSP_IDX : q.
    - out_transparent = oob or (out_index == TRANSP_IDX).
  - When out_valid=0: out_index and out_transparent hold their previous values; consumers ignore them.
- Animation counter (sub-module):
  - Internal tick_cnt counts frame_tick pulses 0..ANIM_DIV-1 while anim_en=1.
  - On a tick with tick_cnt == ANIM_DIV-1: tick_cnt <= 0, and anim_frame <= (anim_frame == ANIM_FRAMES-1) ? 0 : anim_frame+1.
  - anim_en=0: both counters hold.
  - ANIM_FRAMES=1: anim_frame is tied to 0.
  - frame_tick and req_valid in the same cycle: the request uses the pre-tick anim_frame.
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, out_index=0, out_transparent=1, anim_frame=0, tick_cnt=0, all pipeline valids=0.
  - Requests in flight when reset asserts are dropped; no out_valid for them after release.
  - The first request accepted is the one in the first clock edge with reset low.

Optional Feature:
- SPRITE_ROM_HFLIP_EN defined:
  - Adds input port req_hflip (1 bit, placed after req_y).
  - When 1, the effective column is SPR_W-1-req_x, substituted before the address and oob computation.
  - Latency is unchanged.
- Not defined: no req_hflip port; column = req_x.

Decomposition:
- Package sprite_pkg:
  - typedef pal_idx_t (logic [DATA_W-1:0]).
  - localparam TRANSP_IDX_DEFAULT.
  - function sprite_addr(sprite, frame, y, x) used for both RTL and bench address prediction.
- Sub-module sprite_anim_ctr: tick divider plus frame wrap counter; ports clock, reset, frame_tick, anim_en, anim_frame.
- The top level holds the memory and the 2-stage pipeline.

Test Plan:
- Latency/streaming: MIF word k = k mod 8; stream 16 back-to-back requests (sprite 1, frame 0, y=2, x=0..15) -> out_valid on cycles 2..17; out_index = (1*4*32*32 + 2*32 + x) mod 8.
- Animation step: anim_en=1, ANIM_DIV=8; 8 frame_tick pulses -> anim_frame 0->1. 32 pulses -> wraps to 0. anim_en=0 with 8 pulses -> no change.
- Tick collision: request (sprite 0, x=0, y=0) in the same cycle as the 8th tick -> address uses frame 0 (addr 0), not frame 1 (addr 1024).
- Out-of-range: NUM_SPR=3, req_sprite=3 -> out_valid=1, out_index=0, out_transparent=1. A stored index equal to TRANSP_IDX also gives out_transparent=1.
- Reset mid-operation: assert reset with 2 requests in flight -> out_valid=0 immediately, anim_frame=0. No stale out_valid after release; a new request returns 2 cycles later.
- HFLIP (macro on): SPR_W=32, req_x=3, req_hflip=1 -> same out_index as req_x=28, req_hflip=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and address helper for the sprite ROM bank.
package sprite_pkg;

  localparam int unsigned PAL_W              = 3;
  localparam int unsigned TRANSP_IDX_DEFAULT = 0;

  typedef logic [PAL_W-1:0] pal_idx_t;

  // Linear word address of pixel (x, y) in frame `frame` of sprite `sprite`.
  function automatic int unsigned sprite_addr(
    input int unsigned sprite,
    input int unsigned frame,
    input int unsigned y,
    input int unsigned x,
    input int unsigned n_frames,
    input int unsigned spr_h,
    input int unsigned spr_w
  );
    return ((sprite * n_frames + frame) * spr_h + y) * spr_w + x;
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation frame counter: divides frame_tick by ANIM_DIV, then steps a
// wrapping frame index 0..ANIM_FRAMES-1 while anim_en is high.
module sprite_anim_ctr
  import sprite_pkg::*;
#(
  parameter int unsigned ANIM_FRAMES = 4,
  parameter int unsigned ANIM_DIV    = 8,
  localparam int unsigned FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1,
  localparam int unsigned TW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
)
(
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          anim_en,
  output logic [FW-1:0] anim_frame
);

  if (ANIM_FRAMES == 1) begin : g_static
    assign anim_frame = '0;
  end else begin : g_anim
    logic [TW-1:0] tick_cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        tick_cnt   <= '0;
        anim_frame <= '0;
      end else if (frame_tick && anim_en) begin
        if (tick_cnt == TW'(ANIM_DIV - 1)) begin
          tick_cnt   <= '0;
          anim_frame <= (anim_frame == FW'(ANIM_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_rom_bank.sv
// Multi-sprite, multi-frame palette-index ROM with a 2-cycle valid-tagged read
// pipeline. Optional macro SPRITE_ROM_HFLIP_EN adds the req_hflip mirror input.
module sprite_rom_bank
  import sprite_pkg::*;
#(
  parameter int unsigned DATA_W      = PAL_W,
  parameter int unsigned SPR_W       = 32,
  parameter int unsigned SPR_H       = 32,
  parameter int unsigned NUM_SPR     = 4,
  parameter int unsigned ANIM_FRAMES = 4,
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned TRANSP_IDX  = TRANSP_IDX_DEFAULT,
  parameter string       INIT_FILE   = "./sprites/sprites.mif",
  localparam int unsigned SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
  localparam int unsigned XW = (SPR_W > 1) ? $clog2(SPR_W) : 1,
  localparam int unsigned YW = (SPR_H > 1) ? $clog2(SPR_H) : 1,
  localparam int unsigned FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              anim_en,
  input  logic              req_valid,
  input  logic [SW-1:0]     req_sprite,
  input  logic [XW-1:0]     req_x,
  input  logic [YW-1:0]     req_y,
`ifdef SPRITE_ROM_HFLIP_EN
  input  logic              req_hflip,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_index,
  output logic              out_transparent,
  output logic [FW-1:0]     anim_frame
);

  localparam int unsigned DEPTH = NUM_SPR * ANIM_FRAMES * SPR_H * SPR_W;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] TRANSP = DATA_W'(TRANSP_IDX);

  if (INIT_FILE == "") begin : g_init_chk
    $error("sprite_rom_bank: INIT_FILE must name the sprite image");
  end

  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  int unsigned       col_c;
  logic              oob_c;
  logic [AW-1:0]     addr_c;

  logic              s1_valid;
  logic              s1_oob;
  logic [AW-1:0]     s1_addr;

  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] rd_idx_c;
  logic              rd_transp_c;

  sprite_anim_ctr #(
    .ANIM_FRAMES (ANIM_FRAMES),
    .ANIM_DIV    (ANIM_DIV)
  ) u_anim (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .anim_en    (anim_en),
    .anim_frame (anim_frame)
  );

  // Request decode; anim_frame is the pre-tick value when a tick coincides.
  always_comb begin
    col_c = 32'(req_x);
`ifdef SPRITE_ROM_HFLIP_EN
    if (req_hflip) col_c = SPR_W - 1 - 32'(req_x);
`endif
    oob_c  = (32'(req_sprite) >= NUM_SPR) || (col_c >= SPR_W) || (32'(req_y) >= SPR_H);
    addr_c = AW'(sprite_addr(32'(req_sprite), 32'(anim_frame), 32'(req_y), col_c,
                             ANIM_FRAMES, SPR_H, SPR_W));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_oob  <= oob_c;
        s1_addr <= addr_c;
      end
    end
  end

  // Out-of-range pixels are forced to the transparent index.
  always_comb begin
    rd_word_c   = mem[s1_addr];
    rd_idx_c    = s1_oob ? TRANSP : rd_word_c;
    rd_transp_c = s1_oob || (rd_idx_c == TRANSP);
  end

  // Read register doubles as the output stage; data holds between valid beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_index       <= '0;
      out_transparent <= 1'b1;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_index       <= rd_idx_c;
        out_transparent <= rd_transp_c;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_bank.sv
// Self-checking bench for sprite_rom_bank: vector table, streaming, animation,
// tick collision, out-of-range, async reset and (with SPRITE_ROM_HFLIP_EN) mirroring.
module tb_sprite_rom_bank;
  import sprite_pkg::*;

  localparam int unsigned NUM_SPR     = 3;
  localparam int unsigned ANIM_FRAMES = 4;
  localparam int unsigned ANIM_DIV    = 8;
  localparam int unsigned SPR_W       = 32;
  localparam int unsigned SPR_H       = 32;
  localparam int unsigned SW    = 2;
  localparam int unsigned XW    = 5;
  localparam int unsigned YW    = 5;
  localparam int unsigned FW    = 2;
  localparam int unsigned DEPTH = NUM_SPR * ANIM_FRAMES * SPR_H * SPR_W;
  localparam int unsigned AW    = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          anim_en = 1'b0;
  logic          req_valid = 1'b0;
  logic [SW-1:0] req_sprite = '0;
  logic [XW-1:0] req_x = '0;
  logic [YW-1:0] req_y = '0;
`ifdef SPRITE_ROM_HFLIP_EN
  logic          req_hflip = 1'b0;
`endif
  logic          out_valid;
  pal_idx_t      out_index;
  logic          out_transparent;
  logic [FW-1:0] anim_frame;

  sprite_rom_bank #(.NUM_SPR(NUM_SPR)) dut (
    .clock           (clock),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .anim_en         (anim_en),
    .req_valid       (req_valid),
    .req_sprite      (req_sprite),
    .req_x           (req_x),
    .req_y           (req_y),
`ifdef SPRITE_ROM_HFLIP_EN
    .req_hflip       (req_hflip),
`endif
    .out_valid       (out_valid),
    .out_index       (out_index),
    .out_transparent (out_transparent),
    .anim_frame      (anim_frame)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned due;
    pal_idx_t    idx;
    logic        transp;
    string       name;
  } exp_t;

  typedef struct {
    int unsigned spr;
    int unsigned x;
    int unsigned y;
    int unsigned idx;
    logic        transp;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned m_tick = 0;
  int unsigned m_frame = 0;

  // Image preloaded into the ROM: word k = k mod 8, except one marker word.
  function automatic pal_idx_t mem_word(input int unsigned k);
    return (k == 1024) ? 3'd6 : 3'(k % 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    check("anim_frame", 32'(anim_frame), m_frame);
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("stray_valid", 32'(out_valid), 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_lat"}, cyc, e.due);
        check({e.name, "_idx"}, 32'(out_index), 32'(e.idx));
        check({e.name, "_transp"}, 32'(out_transparent), 32'(e.transp));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check({e.name, "_valid"}, 32'(out_valid), 1);
    end
  endtask

  task automatic step();
    if (!reset && frame_tick && anim_en) begin
      if (m_tick == ANIM_DIV - 1) begin
        m_tick  = 0;
        m_frame = (m_frame == ANIM_FRAMES - 1) ? 0 : m_frame + 1;
      end else begin
        m_tick++;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    monitor();
    req_valid  = 1'b0;
    frame_tick = 1'b0;
  endtask

  // Drive one request; expectation is either given or taken from the model.
  task automatic issue(input string name, input int unsigned s, input int unsigned x,
                       input int unsigned y, input bit hf, input bit use_const,
                       input int unsigned cidx, input bit ctr);
    exp_t        e;
    int unsigned col;
    bit          oob;
    req_valid  = 1'b1;
    req_sprite = SW'(s);
    req_x      = XW'(x);
    req_y      = YW'(y);
`ifdef SPRITE_ROM_HFLIP_EN
    req_hflip  = hf;
`endif
    e.due  = cyc + 2;
    e.name = name;
    if (use_const) begin
      e.idx    = 3'(cidx);
      e.transp = ctr;
    end else begin
      col = hf ? (SPR_W - 1 - x) : x;
      oob = (s >= NUM_SPR) || (col >= SPR_W) || (y >= SPR_H);
      e.idx    = oob ? 3'd0 : mem_word(32'(AW'(sprite_addr(s, m_frame, y, col,
                                                         ANIM_FRAMES, SPR_H, SPR_W))));
      e.transp = oob || (e.idx == 3'd0);
    end
    sb.push_back(e);
  endtask

  initial begin
    // {sprite, x, y, expected index, expected transparent} at frame 0
    vecs[0] = '{spr: 0, x: 0,  y: 0,  idx: 0, transp: 1'b1};
    vecs[1] = '{spr: 0, x: 5,  y: 0,  idx: 5, transp: 1'b0};
    vecs[2] = '{spr: 2, x: 7,  y: 31, idx: 7, transp: 1'b0};
    vecs[3] = '{spr: 3, x: 1,  y: 1,  idx: 0, transp: 1'b1};
    vecs[4] = '{spr: 1, x: 9,  y: 3,  idx: 1, transp: 1'b0};
    vecs[5] = '{spr: 0, x: 8,  y: 0,  idx: 0, transp: 1'b1};
    vecs[6] = '{spr: 2, x: 31, y: 31, idx: 7, transp: 1'b0};

    for (int k = 0; k < DEPTH; k++) dut.mem[k] = mem_word(k);

    step();
    step();
    check("reset_valid",  32'(out_valid), 0);
    check("reset_index",  32'(out_index), 0);
    check("reset_transp", 32'(out_transparent), 1);
    check("reset_frame",  32'(anim_frame), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].spr, vecs[i].x, vecs[i].y, 1'b0, 1'b1,
            vecs[i].idx, vecs[i].transp);
      step();
    end
    for (int i = 0; i < 3; i++) step();

    for (int x = 0; x < 16; x++) begin
      issue($sformatf("stream%0d", x), 1, x, 2, 1'b0, 1'b0, 0, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) step();

`ifdef SPRITE_ROM_HFLIP_EN
    issue("hflip_on",  1, 3,  2, 1'b1, 1'b1, 4, 1'b0);
    step();
    issue("hflip_ref", 1, 28, 2, 1'b0, 1'b1, 4, 1'b0);
    step();
    for (int i = 0; i < 3; i++) step();
`endif

    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      frame_tick = 1'b1;
      step();
    end
    check("anim_step", 32'(anim_frame), 1);
    for (int i = 0; i < 24; i++) begin
      frame_tick = 1'b1;
      step();
    end
    check("anim_wrap", 32'(anim_frame), 0);
    anim_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame_tick = 1'b1;
      step();
    end
    check("anim_hold", 32'(anim_frame), 0);

    anim_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b1;
    issue("collide_pre", 0, 0, 0, 1'b0, 1'b1, 0, 1'b1);
    step();
    issue("collide_post", 0, 0, 0, 1'b0, 1'b1, 6, 1'b0);
    step();
    for (int i = 0; i < 3; i++) step();
    check("collide_frame", 32'(anim_frame), 1);

    issue("rst_a", 0, 5, 0, 1'b0, 1'b1, 5, 1'b0);
    step();
    issue("rst_b", 0, 6, 0, 1'b0, 1'b1, 6, 1'b0);
    step();
    issue("rst_c", 0, 7, 0, 1'b0, 1'b1, 7, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid",  32'(out_valid), 0);
    check("rst_async_index",  32'(out_index), 0);
    check("rst_async_transp", 32'(out_transparent), 1);
    check("rst_async_frame",  32'(anim_frame), 0);
    sb.delete();
    m_frame   = 0;
    m_tick    = 0;
    req_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    issue("post_rst", 2, 7, 31, 1'b0, 1'b1, 7, 1'b0);
    step();
    for (int i = 0; i < 5; i++) step();

    for (int i = 0; i < 4 && sb.size() != 0; i++) step();
    check("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
